// File: rtl/mem_stage.sv
// MEM pipeline stage: 256x32 data memory, MEM/WB register and writeback port.
// Define DMEM_ASYNC_READ_EN for combinational-read memory (single-cycle loads, no stall).
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        EX_MEM_MemReadOut,
  input  logic        EX_MEM_MemWriteOut,
  input  logic        EX_MEM_MemtoRegOut,
  input  logic        EX_MEM_RegWrite,
  input  logic [31:0] EX_MEM_ALUResult,
  input  logic [31:0] EX_MEM_WriteData,
  input  logic [4:0]  EX_MEM_WriteReg,
  output logic        MEM_WB_RegWrite,
  output logic        MEM_WB_MemtoReg,
  output logic [31:0] MEM_WB_ReadData,
  output logic [31:0] MEM_WB_ALUResult,
  output logic [4:0]  MEM_WB_WriteReg,
  output logic        RegWrite,
  output logic [31:0] writeData,
  output logic [4:0]  writeReg,
  output logic        MEM_Stall,
  output logic        MEM_AlignErr
);

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] LOAD_WAIT = 1'b1;

  logic [31:0] r_dmem [0:255];
  logic [0:0]  r_state;
  logic        r_wb_reg_write;
  logic        r_wb_mem_to_reg;
  logic [31:0] r_wb_read_data;
  logic [31:0] r_wb_alu;
  logic [4:0]  r_wb_wreg;
  logic        r_align_err;

  logic [7:0]  w_word;
  logic        w_idle;
  logic        w_misaligned;
  logic        w_mem_access;
  logic        w_conflict;
  logic        w_store;
  logic        w_load;

  assign w_word       = EX_MEM_ALUResult[9:2];
  assign w_idle       = (r_state == IDLE);
  assign w_misaligned = |EX_MEM_ALUResult[1:0];
  assign w_mem_access = EX_MEM_MemReadOut | EX_MEM_MemWriteOut;
  assign w_conflict   = EX_MEM_MemReadOut & EX_MEM_MemWriteOut;
  // A read+write request executes as a store; the read half is dropped.
  assign w_store      = rst & w_idle & EX_MEM_MemWriteOut & ~w_misaligned;
  assign w_load       = w_idle & EX_MEM_MemReadOut & ~EX_MEM_MemWriteOut & ~w_misaligned;

  always_ff @(posedge clk) begin
    if (w_store) begin
      r_dmem[w_word] <= EX_MEM_WriteData;
    end
  end

`ifndef DMEM_ASYNC_READ_EN
  logic [31:0] r_rdata;
  logic        r_ld_reg_write;
  logic        r_ld_mem_to_reg;
  logic [31:0] r_ld_alu;
  logic [4:0]  r_ld_wreg;

  // Registered read port; the word is consumed in LOAD_WAIT.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_rdata <= r_dmem[w_word];
    end
  end

  assign MEM_Stall = rst & w_load;
`else
  assign MEM_Stall = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= IDLE;
      r_wb_reg_write  <= 1'b0;
      r_wb_mem_to_reg <= 1'b0;
      r_wb_read_data  <= 32'h0;
      r_wb_alu        <= 32'h0;
      r_wb_wreg       <= 5'd0;
      r_align_err     <= 1'b0;
`ifndef DMEM_ASYNC_READ_EN
      r_ld_reg_write  <= 1'b0;
      r_ld_mem_to_reg <= 1'b0;
      r_ld_alu        <= 32'h0;
      r_ld_wreg       <= 5'd0;
`endif
    end else begin
      r_align_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_align_err     <= (w_mem_access & w_misaligned) | w_conflict;
          r_wb_mem_to_reg <= EX_MEM_MemtoRegOut;
          r_wb_alu        <= EX_MEM_ALUResult;
          r_wb_wreg       <= EX_MEM_WriteReg;
          if (w_load) begin
`ifdef DMEM_ASYNC_READ_EN
            r_wb_reg_write  <= EX_MEM_RegWrite;
            r_wb_read_data  <= r_dmem[w_word];
`else
            // Bubble now; the real result lands from the latches next cycle.
            r_wb_reg_write  <= 1'b0;
            r_ld_reg_write  <= EX_MEM_RegWrite;
            r_ld_mem_to_reg <= EX_MEM_MemtoRegOut;
            r_ld_alu        <= EX_MEM_ALUResult;
            r_ld_wreg       <= EX_MEM_WriteReg;
            r_state         <= LOAD_WAIT;
`endif
          end else if (w_mem_access) begin
            r_wb_reg_write <= 1'b0;
          end else begin
            r_wb_reg_write <= EX_MEM_RegWrite;
          end
        end
        default: begin
`ifndef DMEM_ASYNC_READ_EN
          r_wb_reg_write  <= r_ld_reg_write;
          r_wb_mem_to_reg <= r_ld_mem_to_reg;
          r_wb_read_data  <= r_rdata;
          r_wb_alu        <= r_ld_alu;
          r_wb_wreg       <= r_ld_wreg;
`endif
          r_state         <= IDLE;
        end
      endcase
    end
  end

  assign MEM_WB_RegWrite  = r_wb_reg_write;
  assign MEM_WB_MemtoReg  = r_wb_mem_to_reg;
  assign MEM_WB_ReadData  = r_wb_read_data;
  assign MEM_WB_ALUResult = r_wb_alu;
  assign MEM_WB_WriteReg  = r_wb_wreg;
  assign MEM_AlignErr     = r_align_err;

  // Register 0 is hard-wired: never report a write to it.
  assign RegWrite  = r_wb_reg_write & (r_wb_wreg != 5'd0);
  assign writeReg  = r_wb_wreg;
  assign writeData = r_wb_mem_to_reg ? r_wb_read_data : r_wb_alu;

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-003 SHALL have inputs EX_MEM_MemReadOut, EX_MEM_MemWriteOut, EX_MEM_MemtoRegOut, EX_MEM_RegWrite, each 1 bit: EX/MEM control from EX_STAGE.
REQ-004 SHALL have inputs EX_MEM_ALUResult (32; byte address / ALU value), EX_MEM_WriteData (32; store data) and EX_MEM_WriteReg (5; destination register).
REQ-005 SHALL have outputs MEM_WB_RegWrite, MEM_WB_MemtoReg (1 each), MEM_WB_ReadData, MEM_WB_ALUResult (32 each) and MEM_WB_WriteReg (5): the MEM/WB pipeline register.
REQ-006 SHALL have outputs RegWrite (1), writeData (32) and writeReg (5): writeback port driving ID_STAGE's register file.
REQ-007 SHALL have output MEM_Stall, 1 bit: when 1, upstream freezes PC, IF/ID, ID/EX and EX/MEM.
REQ-008 SHALL have output MEM_AlignErr, 1 bit: registered one-cycle pulse flagging a misaligned access.

Function
REQ-009 SHALL contain a 256 x 32 data memory, word index EX_MEM_ALUResult[9:2]; address bits [31:10] are ignored (address wraps).
REQ-010 SHALL treat an access as misaligned when EX_MEM_ALUResult[1:0] != 0: memory is neither read nor written, MEM_AlignErr=1 next cycle, and MEM_WB_RegWrite=0 for that slot.
REQ-011 SHALL perform a store (MemWriteOut=1, aligned) in one cycle: memory written at the rising edge, MEM_Stall stays 0, MEM_WB_RegWrite=0.
REQ-012 SHALL, when MemReadOut and MemWriteOut are both 1, execute the store only, suppress the read, and pulse MEM_AlignErr.
REQ-013 SHALL implement FSM states IDLE and LOAD_WAIT.
REQ-014 In IDLE, on an aligned load, SHALL issue the synchronous RAM read, latch WriteReg/MemtoReg/ALUResult, assert MEM_Stall combinationally in that cycle, load a bubble (RegWrite=0) into MEM/WB, and go to LOAD_WAIT.
REQ-015 In LOAD_WAIT, SHALL hold MEM_Stall=0, load RAM output and latched fields into MEM/WB with RegWrite=EX_MEM_RegWrite as latched, and return to IDLE; total load latency = 2 cycles from EX/MEM to MEM/WB.
REQ-016 SHALL ignore EX/MEM inputs while in LOAD_WAIT; the next EX/MEM value is consumed in IDLE.
REQ-017 SHALL, for non-memory ops in IDLE, copy RegWrite, MemtoReg, ALUResult and WriteReg into MEM/WB in one cycle; MEM_WB_ReadData holds its previous value.
REQ-018 SHALL drive RegWrite=MEM_WB_RegWrite, writeReg=MEM_WB_WriteReg and writeData=(MEM_WB_MemtoReg ? MEM_WB_ReadData : MEM_WB_ALUResult) combinationally.
REQ-019 SHALL force RegWrite=0 when writeReg=0 (register 0 is never written).
REQ-020 SHALL let a load issued the cycle after a store to the same word return the new stored data.

Reset
REQ-021 SHALL, on rst=0, asynchronously clear all MEM/WB outputs, MEM_AlignErr and MEM_Stall to 0 and force the FSM to IDLE.
REQ-022 SHALL not clear data memory contents on reset.
REQ-023 SHALL abort a load in progress when reset asserts mid-load: no write back occurs and the FSM resumes in IDLE.

Configuration
REQ-024 With macro DMEM_ASYNC_READ_EN defined, SHALL read memory combinationally, complete loads in 1 cycle, hold MEM_Stall at 0, and never enter LOAD_WAIT.
REQ-025 Without DMEM_ASYNC_READ_EN, SHALL use the 2-cycle synchronous-read FSM of REQ-013..REQ-016.

Verification
REQ-026 Store 0xDEADBEEF to address 0x10, then load from 0x10 with WriteReg=5 -> MEM_Stall=1 for one cycle; next cycle RegWrite=1, writeReg=5, writeData=0xDEADBEEF.
REQ-027 Non-memory op, ALUResult=0x0000002A, WriteReg=3, RegWrite=1 -> one cycle later writeData=0x2A, writeReg=3, MEM_Stall=0.
REQ-028 Load from 0x13 -> no stall, MEM_AlignErr=1 for one cycle, RegWrite=0.
REQ-029 Store 0x55 to 0x404 (wraps to word 1), load from 0x004 -> writeData=0x55.
REQ-030 Load issued, rst=0 during LOAD_WAIT -> all outputs 0 immediately, FSM in IDLE, no write back after rst=1.
REQ-031 Rebuild with DMEM_ASYNC_READ_EN and repeat REQ-026 -> MEM_Stall stays 0 and writeData=0xDEADBEEF one cycle after the load.
